// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // A length is loadable when it is word aligned and fits in the memory.
    function automatic logic len_valid(input logic [15:0] len, input int unsigned mem_bytes);
        return (len[1:0] == 2'b00) && ({16'd0, len} <= mem_bytes);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, memory write port and status bundle of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte of a group lands in bits [31:24].
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    // Only three bytes need storing; the fourth is taken straight from the input.
    logic [23:0] r_word;
    logic [1:0]  r_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_shift) begin
            r_word <= {r_word[15:0], i_byte};
            r_lane <= r_lane + 2'd1;
        end
    end

    assign o_word      = {r_word, i_byte};
    assign o_word_full = i_shift && (r_lane == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + image bytes -> word writes into instruction memory.
// Optional trailing XOR checksum byte is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t            r_state, w_next;
    logic [15:0]       r_len;
    logic [15:0]       r_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    logic              w_in_ready, w_hold, w_done, w_err;
    logic              w_start, w_accept, w_shift, w_last;
    logic [15:0]       w_len_full;
    logic [31:0]       w_word;
    logic              w_word_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    assign w_start    = bus.start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_shift    = w_accept && (r_state == S_DATA);
    assign w_len_full = {r_len[15:8], bus.in_byte};
    assign w_last     = (r_cnt == r_len - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Transitions use in_valid directly: every state that moves on a byte has in_ready high.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_hold     = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_in_ready = 1'b1;
                w_hold     = 1'b1;
                if (bus.in_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_in_ready = 1'b1;
                w_hold     = 1'b1;
                if (bus.in_valid) begin
                    if (!len_valid(w_len_full, MEM_BYTES)) w_next = S_ERR;
                    else if (w_len_full == 16'd0)          w_next = S_AFTER_DATA;
                    else                                   w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                w_hold     = 1'b1;
                if (bus.in_valid && w_last) w_next = S_AFTER_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                w_in_ready = 1'b1;
                w_hold     = 1'b1;
                if (bus.in_valid) w_next = (bus.in_byte == r_csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_next = S_LEN_HI;
            end
            S_ERR: begin
                w_err  = 1'b1;
                w_hold = 1'b1;
                if (bus.start) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_LEN_HI: r_len[15:8] <= bus.in_byte;
                S_LEN_LO: r_len[7:0]  <= bus.in_byte;
                S_DATA:   r_cnt       <= r_cnt + 16'd1;
                default:  ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_csum <= '0;
        else if (w_start) r_csum <= '0;
        else if (w_shift) r_csum <= r_csum ^ bus.in_byte;
    end
`endif

    // Address and data stay put between strobes so the memory side may sample late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_word_full;
            if (w_word_full) begin
                r_wr_addr <= ADDR_W'(r_cnt & 16'hFFFC);
                r_wr_data <= w_word;
            end
        end
    end

    imem_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_start),
        .i_shift     (w_shift),
        .i_byte      (bus.in_byte),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.cpu_hold = w_hold;
    assign bus.done     = w_done;
    assign bus.err      = w_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus randomized images and gaps.
module tb_imem_loader;
    localparam int MEM_BYTES = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if #(.ADDR_W(32)) bus();

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] got_q[$];
    logic [7:0]  data_q[MEM_BYTES];

    always @(negedge clk)
        if (rst_n && bus.wr_en) got_q.push_back({bus.wr_addr, bus.wr_data});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gaps, input string tag);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] len, input bit gaps, input bit bad_cs,
                            input bit mid_start, input string tag);
        logic [63:0] exp_q[$];
        logic [7:0]  cs;
        bit          len_ok;
        bit          exp_err;
        cs      = 8'h00;
        len_ok  = (len % 4 == 0) && (int'(len) <= MEM_BYTES);
        exp_err = !len_ok;
        if (len_ok) begin
            for (int i = 0; i < int'(len); i += 4)
                exp_q.push_back({32'(i), data_q[i], data_q[i+1], data_q[i+2], data_q[i+3]});
            for (int i = 0; i < int'(len); i++) cs ^= data_q[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (bad_cs) exp_err = 1'b1;
`endif
        end
        got_q.delete();
        pulse_start();
        check({tag, "_ready_after_start"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_hold_after_start"}, 64'(bus.cpu_hold), 64'd1);
        check({tag, "_done_cleared"}, 64'({bus.done, bus.err}), 64'd0);
        send(len[15:8], gaps, tag);
        send(len[7:0], gaps, tag);
        if (!len_ok) begin
            check({tag, "_err_after_hdr"}, 64'(bus.err), 64'd1);
            check({tag, "_hold_in_err"}, 64'(bus.cpu_hold), 64'd1);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                send(data_q[i], gaps, tag);
                if (mid_start && i == 3) pulse_start();
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send(bad_cs ? (cs ^ 8'h01) : cs, gaps, tag);
`else
            if (len != 16'd0) check({tag, "_last_wr_with_done"}, 64'(bus.wr_en), 64'd1);
`endif
            check({tag, "_done"}, 64'(bus.done), 64'(!exp_err));
            check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
            check({tag, "_hold_end"}, 64'(bus.cpu_hold), 64'(exp_err));
        end
        check({tag, "_ready_end"}, 64'(bus.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[k]) check({tag, "_write"}, (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]);
        check({tag, "_sticky"}, 64'({bus.done, bus.err}), 64'({!exp_err, exp_err}));
    endtask

    task automatic load_basic_image();
        logic [7:0] img[8];
        img = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93};
        foreach (img[i]) data_q[i] = img[i];
    endtask

    initial begin
        logic [15:0] len;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        foreach (data_q[i]) data_q[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check("rst_outputs", {bus.in_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.err}, 64'd0);
        check("rst_addr_data", {bus.wr_addr, bus.wr_data}, 64'd0);
        rst_n = 1'b1;

        // Bytes offered while idle must not be consumed.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hAA;
        repeat (2) @(negedge clk);
        check("idle_ready", 64'(bus.in_ready), 64'd0);
        check("idle_hold", 64'(bus.cpu_hold), 64'd0);
        bus.in_valid = 1'b0;

        load_basic_image();
        run_load(16'h0008, 1'b0, 1'b0, 1'b0, "basic");
        check("basic_w0", got_q.size() > 0 ? got_q[0] : 64'hx, 64'h00000000_00000013);
        check("basic_w1", got_q.size() > 1 ? got_q[1] : 64'hx, 64'h00000004_00500093);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        repeat (3) @(negedge clk);
        check("done_ignores_valid", 64'({bus.in_ready, bus.done}), 64'b01);
        check("done_no_extra_wr", 64'(got_q.size()), 64'd2);
        bus.in_valid = 1'b0;

        run_load(16'h0006, 1'b0, 1'b0, 1'b0, "len6");
        run_load(16'h0084, 1'b0, 1'b0, 1'b0, "len84");
        run_load(16'h0000, 1'b0, 1'b0, 1'b0, "len0");

        load_basic_image();
        run_load(16'h0008, 1'b1, 1'b0, 1'b1, "gaps");

        foreach (data_q[i]) data_q[i] = 8'($urandom);
        run_load(16'(MEM_BYTES), 1'b1, 1'b0, 1'b0, "max");

        for (int r = 0; r < 6; r++) begin
            foreach (data_q[i]) data_q[i] = 8'($urandom);
            len = 16'($urandom_range(0, 32) * 4);
            if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(1, 300));
            run_load(len, 1'($urandom), 1'b0, 1'b0, "rand");
        end

        // Reset in the middle of the data phase.
        load_basic_image();
        got_q.delete();
        pulse_start();
        send(8'h00, 1'b0, "rstmid");
        send(8'h08, 1'b0, "rstmid");
        for (int i = 0; i < 3; i++) send(data_q[i], 1'b0, "rstmid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_ctrl", {bus.in_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.err}, 64'd0);
        check("rstmid_addr_data", {bus.wr_addr, bus.wr_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_nowr", 64'(got_q.size()), 64'd0);
        run_load(16'h0008, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        load_basic_image();
        run_load(16'h0008, 1'b0, 1'b0, 1'b0, "cs_good");
        run_load(16'h0008, 1'b0, 1'b1, 1'b0, "cs_bad");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
